// File: rtl/unary_expander_12.sv
// ---------------------------------------------------------------------------
// unary_expander_12
//   Expands a CW-bit count (0..N_BITS) into an N_BITS-long unary word that
//   is emitted bit-serially, LSB first. The first cnt bits are 1 and the rest
//   are 0. Valid/ready handshakes on both sides. One word is buffered, and a
//   new count can load on the last-bit transfer so that back-to-back words
//   have no bubble between them.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-high reset
//     in_valid   in   in_count is valid
//     in_ready   out  expander can accept a count this cycle (combinational)
//     in_count   in   [CW-1:0] number of 1-bits; values above N_BITS are clamped
//     out_valid  out  out_bit is valid
//     out_ready  in   downstream accepts out_bit this cycle
//     out_bit    out  current unary bit
//     out_last   out  marks bit index N_BITS-1 of the current word
//     sat_err    out  one-cycle pulse after accepting in_count > N_BITS
//     out_vec    out  [N_BITS-1:0] thermometer code of the loaded count
//                     (present only with UNARY_EXPANDER_PAR_OUT_EN defined)
//
//   Build option: define UNARY_EXPANDER_PAR_OUT_EN to add the registered
//   parallel thermometer output out_vec. The serial path is the same either way.
// ---------------------------------------------------------------------------
module unary_expander_12 #(
    parameter int N_BITS = 12,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
`ifdef UNARY_EXPANDER_PAR_OUT_EN
    output logic [N_BITS-1:0] out_vec,
`endif
    output logic              sat_err
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [CW-1:0] MAX_CNT  = CW'(N_BITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BITS - 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_idx;
    logic            r_sat_err;

    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_over;
    logic [CW-1:0]   w_clamp;

    // The output side is valid exactly while a word is being shifted out.
    assign out_valid = (r_state == SHIFT);
    assign out_bit   = (r_idx < r_cnt);
    assign out_last  = (r_idx == LAST_IDX);
    assign sat_err   = r_sat_err;

    assign w_out_xfer = out_valid & out_ready;
    // Reset forces IDLE, so in_ready reads 1 during reset. The async reset
    // branch below keeps any in_valid from loading while reset is high.
    assign in_ready   = (r_state == IDLE) | (w_out_xfer & out_last);
    assign w_in_xfer  = in_valid & in_ready;

    assign w_over  = (in_count > MAX_CNT);
    assign w_clamp = w_over ? MAX_CNT : in_count;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state. A load that happens in the same cycle as the last-bit
    // transfer takes priority, so the FSM stays in SHIFT and no bubble appears.
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_xfer)
            w_state_nxt = SHIFT;
        else if (w_out_xfer && out_last)
            w_state_nxt = IDLE;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_sat_err <= 1'b0;
        end else begin
            r_sat_err <= w_in_xfer & w_over;
            if (w_in_xfer) begin
                r_cnt <= w_clamp;
                r_idx <= '0;
            end else if (w_out_xfer && !out_last) begin
                r_idx <= r_idx + CW'(1);
            end
        end
    end

`ifdef UNARY_EXPANDER_PAR_OUT_EN
    logic [N_BITS-1:0] w_therm;
    logic [N_BITS-1:0] r_vec;

    always_comb begin
        w_therm = '0;
        for (int k = 0; k < N_BITS; k++)
            w_therm[k] = (CW'(k) < w_clamp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_vec <= '0;
        else if (w_in_xfer) r_vec <= w_therm;
    end

    assign out_vec = r_vec;
`endif

endmodule
